// File: rtl/pio_pkg.sv
// Shared constants for the PIO family: register word addresses and
// the encodings of the EDGE_TYPE and IRQ_MODE parameters.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_EDGE  = 0;
  localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/nios_system_pio_in_edge_if.sv
// Avalon-MM slave bus of the input PIO, plus its interrupt line.
interface nios_system_pio_in_edge_if;

  // A transfer happens on every clock where chipselect is high; there are no
  // wait states. Reads return readdata on the following clock, and
  // write_n low marks the transfer as a write.
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );

endinterface

// File: rtl/pio_bit_sync.sv
// Multi-bit flop-chain synchroniser with synchronous reset; each bit is
// synchronised independently, so multi-bit values may arrive skewed.
module pio_bit_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/nios_system_pio_in_edge.sv
// Parametrised input PIO: synchronised DATA, per-bit edge capture with
// write-1-to-clear, interrupt mask and a registered level/edge IRQ.
module nios_system_pio_in_edge
  import pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_MODE    = 0,
  parameter logic [31:0] RESET_MASK  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  nios_system_pio_in_edge_if.slave avs
);

  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] r_sync_d;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] r_edge_cap;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [2:0]            r_arm_cnt;
  logic                  w_armed;
  logic                  w_wr;
  logic                  w_irq_next;
  logic [31:0]           w_rd_mux;
  logic [31:0]           r_readdata;
  logic                  r_irq;

  pio_bit_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (in_port),
    .o_q   (w_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_d <= '0;
    end else begin
      r_sync_d <= w_sync;
    end
  end

  // The chain comes out of reset full of zeros; hold off edge detection
  // until it has been flushed by real input samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arm_cnt <= 3'd0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  assign w_armed = (r_arm_cnt == ARM_DONE);

  assign w_rise = w_sync & ~r_sync_d;
  assign w_fall = ~w_sync & r_sync_d;

  always_comb begin
    w_edge = '0;
    if (w_armed) begin
      case (EDGE_TYPE)
        EDGE_RISE: w_edge = w_rise;
        EDGE_FALL: w_edge = w_fall;
        default:   w_edge = w_rise | w_fall;
      endcase
    end
  end

  assign w_wr    = avs.chipselect & ~avs.write_n;
  assign w_wdata = avs.writedata[DATA_WIDTH-1:0];
  assign w_clr   = (w_wr && (avs.address == ADDR_EDGE)) ? w_wdata : '0;

  // A new edge beats a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge_cap <= '0;
    end else begin
      r_edge_cap <= w_edge | (r_edge_cap & ~w_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= RESET_MASK[DATA_WIDTH-1:0];
    end else if (w_wr && (avs.address == ADDR_MASK)) begin
      r_mask <= w_wdata;
    end
  end

  assign w_irq_next = (IRQ_MODE == IRQ_LEVEL) ? |(w_sync & r_mask)
                                              : |(r_edge_cap & r_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_next;
    end
  end

  always_comb begin
    w_rd_mux = 32'h0;
    case (avs.address)
      ADDR_DATA: w_rd_mux = 32'(w_sync);
      ADDR_MASK: w_rd_mux = 32'(r_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge_cap);
      default:   w_rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'h0;
    end else if (avs.chipselect) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign avs.readdata = r_readdata;
  assign avs.irq      = r_irq;

  if (DATA_WIDTH < 32) begin : g_unused_wdata
    logic w_unused_wdata;
    assign w_unused_wdata = ^avs.writedata[31:DATA_WIDTH];
  end

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Bench for the input PIO: two configurations side by side, directed steps
// followed by random traffic, all compared against a cycle-level model.
module tb_nios_system_pio_in_edge;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in0;
  logic [7:0]  in1;

  always #5 clk = ~clk;

  nios_system_pio_in_edge_if bus0 ();
  nios_system_pio_in_edge_if bus1 ();

  nios_system_pio_in_edge #(
    .DATA_WIDTH (32), .SYNC_STAGES (2), .EDGE_TYPE (EDGE_RISE),
    .IRQ_MODE (IRQ_EDGE), .RESET_MASK (32'h0)
  ) u_dut0 (
    .clk (clk), .reset (reset), .in_port (in0), .avs (bus0)
  );

  nios_system_pio_in_edge #(
    .DATA_WIDTH (8), .SYNC_STAGES (3), .EDGE_TYPE (EDGE_ANY),
    .IRQ_MODE (IRQ_LEVEL), .RESET_MASK (32'h1)
  ) u_dut1 (
    .clk (clk), .reset (reset), .in_port (in1), .avs (bus1)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference configuration and state, one entry per DUT.
  int          cfg_n  [2] = '{2, 3};
  logic [31:0] cfg_w  [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  int          cfg_et [2] = '{0, 2};
  int          cfg_im [2] = '{0, 1};
  logic [31:0] cfg_rm [2] = '{32'h0, 32'h1};

  logic [31:0] m_hist  [2][6];
  int          m_since [2];
  logic [31:0] m_cap   [2];
  logic [31:0] m_mask  [2];
  logic [31:0] m_rd    [2];
  logic        m_irq   [2];

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input int k, input logic [1:0] addr, input logic cs,
                         input logic wn, input logic [31:0] wd);
    if (k == 0) begin
      bus0.address = addr; bus0.chipselect = cs;
      bus0.write_n = wn;   bus0.writedata  = wd;
    end else begin
      bus1.address = addr; bus1.chipselect = cs;
      bus1.write_n = wn;   bus1.writedata  = wd;
    end
  endtask

  task automatic idle_all();
    set_bus(0, 2'd0, 1'b0, 1'b1, 32'h0);
    set_bus(1, 2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  // One clock: advance the model with the inputs present at the edge,
  // then compare both DUTs' outputs shortly after the edge.
  task automatic tick();
    logic [1:0]  a   [2];
    logic        cs  [2];
    logic        wn  [2];
    logic [31:0] wd  [2];
    logic [31:0] inp [2];
    logic [31:0] sy, sd, ri, fa, ev, cl, w;
    logic        wr_v;
    int          n;
    a[0] = bus0.address; cs[0] = bus0.chipselect; wn[0] = bus0.write_n;
    wd[0] = bus0.writedata; inp[0] = in0;
    a[1] = bus1.address; cs[1] = bus1.chipselect; wn[1] = bus1.write_n;
    wd[1] = bus1.writedata; inp[1] = {24'h0, in1};
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      n = cfg_n[k];
      w = cfg_w[k];
      sy = m_hist[k][n-1];
      sd = m_hist[k][n];
      if (reset) begin
        for (int j = 0; j < 6; j++) m_hist[k][j] = 32'h0;
        m_since[k] = 0;
        m_cap[k]   = 32'h0;
        m_mask[k]  = cfg_rm[k] & w;
        m_rd[k]    = 32'h0;
        m_irq[k]   = 1'b0;
      end else begin
        wr_v = cs[k] & ~wn[k];
        ri = sy & ~sd;
        fa = ~sy & sd;
        ev = 32'h0;
        if (m_since[k] > n)
          ev = (cfg_et[k] == 0) ? ri : (cfg_et[k] == 1) ? fa : (ri | fa);
        cl = (wr_v && a[k] == 2'd3) ? (wd[k] & w) : 32'h0;
        if (cs[k])
          m_rd[k] = (a[k] == 2'd0) ? sy : (a[k] == 2'd2) ? m_mask[k] :
                    (a[k] == 2'd3) ? m_cap[k] : 32'h0;
        m_irq[k] = (cfg_im[k] == 1) ? |(sy & m_mask[k]) : |(m_cap[k] & m_mask[k]);
        m_cap[k] = ev | (m_cap[k] & ~cl);
        if (wr_v && a[k] == 2'd2) m_mask[k] = wd[k] & w;
        for (int j = 5; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = inp[k] & w;
        if (m_since[k] < 1000) m_since[k]++;
      end
    end
    #1;
    if (chk_en) begin
      check32("model_rd0", bus0.readdata, m_rd[0]);
      check32("model_irq0", {31'h0, bus0.irq}, {31'h0, m_irq[0]});
      check32("model_rd1", bus1.readdata, m_rd[1]);
      check32("model_irq1", {31'h0, bus1.irq}, {31'h0, m_irq[1]});
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input int k, input logic [1:0] addr);
    set_bus(k, addr, 1'b1, 1'b1, 32'h0);
    tick();
    set_bus(k, 2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic wr(input int k, input logic [1:0] addr, input logic [31:0] data);
    set_bus(k, addr, 1'b1, 1'b0, data);
    tick();
    set_bus(k, 2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    idle_all();
    in0 = 32'hFFFF_FFFF;
    in1 = 8'h00;
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    ticks(2);
    check32("reset_rd0", bus0.readdata, 32'h0);
    check32("reset_irq0", {31'h0, bus0.irq}, 32'h0);
    check32("reset_rd1", bus1.readdata, 32'h0);
    check32("reset_irq1", {31'h0, bus1.irq}, 32'h0);

    // Inputs high through reset release must not look like edges.
    reset = 1'b0;
    ticks(6);
    rd(0, 2'd3);
    check32("no_false_edge", bus0.readdata, 32'h0);
    rd(0, 2'd0);
    check32("data_ones", bus0.readdata, 32'hFFFF_FFFF);

    in0 = 32'hA5A5_0F0F;
    set_bus(0, 2'd0, 1'b1, 1'b1, 32'h0);
    ticks(2);
    check32("data_not_yet", bus0.readdata, 32'hFFFF_FFFF);
    tick();
    check32("data_latency", bus0.readdata, 32'hA5A5_0F0F);
    set_bus(0, 2'd0, 1'b0, 1'b1, 32'h0);
    rd(0, 2'd1);
    check32("rsvd_zero", bus0.readdata, 32'h0);
    wr(0, 2'd1, 32'hDEAD_BEEF);
    wr(0, 2'd0, 32'h1234_5678);
    rd(0, 2'd1);
    check32("rsvd_write_ignored", bus0.readdata, 32'h0);
    check32("irq0_idle", {31'h0, bus0.irq}, 32'h0);

    in0 = 32'h0;
    ticks(5);
    in0 = 32'h8;
    ticks(3);
    rd(0, 2'd3);
    check32("edge_rise_b3", bus0.readdata, 32'h8);
    wr(0, 2'd3, 32'h8);
    rd(0, 2'd3);
    check32("edge_cleared", bus0.readdata, 32'h0);
    in0 = 32'h0;
    ticks(5);
    rd(0, 2'd3);
    check32("fall_ignored", bus0.readdata, 32'h0);

    wr(0, 2'd2, 32'h8);
    rd(0, 2'd2);
    check32("mask_rd", bus0.readdata, 32'h8);
    in0 = 32'h8;
    ticks(3);
    check32("irq_not_yet", {31'h0, bus0.irq}, 32'h0);
    tick();
    check32("irq_set", {31'h0, bus0.irq}, 32'h1);
    wr(0, 2'd3, 32'h8);
    check32("irq_hold", {31'h0, bus0.irq}, 32'h1);
    tick();
    check32("irq_clr", {31'h0, bus0.irq}, 32'h0);

    in0 = 32'h28;
    ticks(2);
    wr(0, 2'd3, 32'h20);
    rd(0, 2'd3);
    check32("set_wins", bus0.readdata, 32'h20);

    in1 = 8'h01;
    ticks(3);
    check32("lvl_irq_not_yet", {31'h0, bus1.irq}, 32'h0);
    tick();
    check32("lvl_irq_set", {31'h0, bus1.irq}, 32'h1);
    in1 = 8'h00;
    ticks(3);
    check32("lvl_irq_hold", {31'h0, bus1.irq}, 32'h1);
    tick();
    check32("lvl_irq_clr", {31'h0, bus1.irq}, 32'h0);
    in1 = 8'hFF;
    ticks(4);
    rd(1, 2'd0);
    check32("data8", bus1.readdata, 32'h0000_00FF);
    wr(1, 2'd2, 32'hFFFF_FF00);
    rd(1, 2'd2);
    check32("mask8_upper_zero", bus1.readdata, 32'h0);
    rd(1, 2'd3);
    check32("any_edge", bus1.readdata, 32'h0000_00FF);
    wr(1, 2'd3, 32'hFFFF_FFFF);
    rd(1, 2'd3);
    check32("any_edge_cleared", bus1.readdata, 32'h0);

    // Reset must win over a write landing in the same cycle.
    set_bus(0, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_all();
    rd(0, 2'd2);
    check32("reset_over_write", bus0.readdata, 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in0 = $urandom();
      if ($urandom_range(0, 3) == 0) in1 = 8'($urandom());
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0: set_bus(k, 2'd0, 1'b0, 1'b1, 32'h0);
          1: set_bus(k, 2'($urandom_range(0, 3)), 1'b1, 1'b1, 32'h0);
          default: set_bus(k, 2'($urandom_range(0, 3)), 1'b1, 1'b0, $urandom());
        endcase
      end
      reset = (i == 200);
      tick();
    end
    reset = 1'b0;
    idle_all();
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
